// File: rtl/i2c_arbiter.sv
// Two-requester arbiter in front of a single I2C master core.
// Round-robin grant, held across busy transactions, direct handoff.
//
// Ports:
//   Clk_i, Reset_n_i        clock, async active-low reset
//   ReqN_i / GntN_o         ownership request / grant (N = 0, 1)
//   ReqN_* inputs           requester N core controls, read count, write data
//   ReqN_Busy/Error/Data_o  core status as seen by requester N
//   I2C_* outputs           muxed controls towards the core
//   I2C_Busy/Error/Data_i   status and read data from the core
module i2c_arbiter (
    input  logic       Clk_i,
    input  logic       Reset_n_i,

    input  logic       Req0_i,
    output logic       Gnt0_o,
    input  logic       Req0_ReceiveSend_n_i,
    input  logic       Req0_StartProcess_i,
    input  logic       Req0_FIFOReadNext_i,
    input  logic       Req0_FIFOWrite_i,
    input  logic [7:0] Req0_ReadCount_i,
    input  logic [7:0] Req0_Data_i,
    output logic       Req0_Busy_o,
    output logic       Req0_Error_o,
    output logic [7:0] Req0_Data_o,

    input  logic       Req1_i,
    output logic       Gnt1_o,
    input  logic       Req1_ReceiveSend_n_i,
    input  logic       Req1_StartProcess_i,
    input  logic       Req1_FIFOReadNext_i,
    input  logic       Req1_FIFOWrite_i,
    input  logic [7:0] Req1_ReadCount_i,
    input  logic [7:0] Req1_Data_i,
    output logic       Req1_Busy_o,
    output logic       Req1_Error_o,
    output logic [7:0] Req1_Data_o,

    output logic       I2C_ReceiveSend_n_o,
    output logic       I2C_StartProcess_o,
    output logic       I2C_FIFOReadNext_o,
    output logic       I2C_FIFOWrite_o,
    output logic [7:0] I2C_ReadCount_o,
    output logic [7:0] I2C_Data_o,
    input  logic       I2C_Busy_i,
    input  logic       I2C_Error_i,
    input  logic [7:0] I2C_Data_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   last_gnt_q;
    logic   gnt0;
    logic   gnt1;

    // Reset leaves last_gnt at 1 so requester 0 wins the first tie.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_d == GNT0 && state_q != GNT0) begin
                last_gnt_q <= 1'b0;
            end else if (state_d == GNT1 && state_q != GNT1) begin
                last_gnt_q <= 1'b1;
            end
        end
    end

    // A grant is kept while its owner requests or the core is busy,
    // so a transaction in flight is never cut off.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (Req0_i && Req1_i) begin
                    state_d = last_gnt_q ? GNT0 : GNT1;
                end else if (Req0_i) begin
                    state_d = GNT0;
                end else if (Req1_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!Req0_i && !I2C_Busy_i) begin
                    state_d = Req1_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!Req1_i && !I2C_Busy_i) begin
                    state_d = Req0_i ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grants decode straight from the state register: one-hot, glitch-free.
    assign gnt0   = (state_q == GNT0);
    assign gnt1   = (state_q == GNT1);
    assign Gnt0_o = gnt0;
    assign Gnt1_o = gnt1;

    // Non-owners see a permanently busy core and have their strobes
    // discarded, not queued.
    always_comb begin
        I2C_ReceiveSend_n_o = 1'b0;
        I2C_StartProcess_o  = 1'b0;
        I2C_FIFOReadNext_o  = 1'b0;
        I2C_FIFOWrite_o     = 1'b0;
        I2C_ReadCount_o     = 8'h00;
        I2C_Data_o          = 8'h00;
        Req0_Busy_o         = 1'b1;
        Req0_Error_o        = 1'b0;
        Req0_Data_o         = 8'h00;
        Req1_Busy_o         = 1'b1;
        Req1_Error_o        = 1'b0;
        Req1_Data_o         = 8'h00;
        unique case (1'b1)
            gnt0: begin
                I2C_ReceiveSend_n_o = Req0_ReceiveSend_n_i;
                I2C_StartProcess_o  = Req0_StartProcess_i;
                I2C_FIFOReadNext_o  = Req0_FIFOReadNext_i;
                I2C_FIFOWrite_o     = Req0_FIFOWrite_i;
                I2C_ReadCount_o     = Req0_ReadCount_i;
                I2C_Data_o          = Req0_Data_i;
                Req0_Busy_o         = I2C_Busy_i;
                Req0_Error_o        = I2C_Error_i;
                Req0_Data_o         = I2C_Data_i;
            end
            gnt1: begin
                I2C_ReceiveSend_n_o = Req1_ReceiveSend_n_i;
                I2C_StartProcess_o  = Req1_StartProcess_i;
                I2C_FIFOReadNext_o  = Req1_FIFOReadNext_i;
                I2C_FIFOWrite_o     = Req1_FIFOWrite_i;
                I2C_ReadCount_o     = Req1_ReadCount_i;
                I2C_Data_o          = Req1_Data_i;
                Req1_Busy_o         = I2C_Busy_i;
                Req1_Error_o        = I2C_Error_i;
                Req1_Data_o         = I2C_Data_i;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: reset, grant, mux, hold-while-busy,
// handoff, round robin, dropped strobes and mid-transaction reset.
module tb_i2c_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       req0 = 1'b0, req1 = 1'b0;
    logic       gnt0, gnt1;
    logic       r0_rs = 1'b0, r0_sp = 1'b0, r0_rn = 1'b0, r0_fw = 1'b0;
    logic       r1_rs = 1'b0, r1_sp = 1'b0, r1_rn = 1'b0, r1_fw = 1'b0;
    logic [7:0] r0_rc = 8'h00, r0_d = 8'h00;
    logic [7:0] r1_rc = 8'h00, r1_d = 8'h00;
    logic       r0_busy, r0_err, r1_busy, r1_err;
    logic [7:0] r0_dout, r1_dout;
    logic       c_rs, c_sp, c_rn, c_fw;
    logic [7:0] c_rc, c_d;
    logic       c_busy = 1'b0, c_err = 1'b0;
    logic [7:0] c_din = 8'h00;

    int n_chk = 0;
    int n_fail = 0;
    int owner;

    always #5 clk = ~clk;

    i2c_arbiter dut (
        .Clk_i                (clk),
        .Reset_n_i            (rst_n),
        .Req0_i               (req0),
        .Gnt0_o               (gnt0),
        .Req0_ReceiveSend_n_i (r0_rs),
        .Req0_StartProcess_i  (r0_sp),
        .Req0_FIFOReadNext_i  (r0_rn),
        .Req0_FIFOWrite_i     (r0_fw),
        .Req0_ReadCount_i     (r0_rc),
        .Req0_Data_i          (r0_d),
        .Req0_Busy_o          (r0_busy),
        .Req0_Error_o         (r0_err),
        .Req0_Data_o          (r0_dout),
        .Req1_i               (req1),
        .Gnt1_o               (gnt1),
        .Req1_ReceiveSend_n_i (r1_rs),
        .Req1_StartProcess_i  (r1_sp),
        .Req1_FIFOReadNext_i  (r1_rn),
        .Req1_FIFOWrite_i     (r1_fw),
        .Req1_ReadCount_i     (r1_rc),
        .Req1_Data_i          (r1_d),
        .Req1_Busy_o          (r1_busy),
        .Req1_Error_o         (r1_err),
        .Req1_Data_o          (r1_dout),
        .I2C_ReceiveSend_n_o  (c_rs),
        .I2C_StartProcess_o   (c_sp),
        .I2C_FIFOReadNext_o   (c_rn),
        .I2C_FIFOWrite_o      (c_fw),
        .I2C_ReadCount_o      (c_rc),
        .I2C_Data_o           (c_d),
        .I2C_Busy_i           (c_busy),
        .I2C_Error_i          (c_err),
        .I2C_Data_i           (c_din)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic edge_chk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, with noise on core inputs that must not leak through
        c_din = 8'hAA;
        c_err = 1'b1;
        r0_sp = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_busy0", r0_busy, 1);
        chk("rst_busy1", r1_busy, 1);
        chk("rst_err0", r0_err, 0);
        chk("rst_dout0", r0_dout, 0);
        chk("rst_dout1", r1_dout, 0);
        chk("rst_csp", c_sp, 0);
        r0_sp = 1'b0;
        c_din = 8'h00;
        c_err = 1'b0;

        @(negedge clk);
        rst_n = 1'b1;

        // Tie after reset goes to requester 0
        @(negedge clk);
        req0 = 1'b1;
        req1 = 1'b1;
        edge_chk();
        chk("tie_gnt0", gnt0, 1);
        chk("tie_gnt1", gnt1, 0);
        chk("tie_busy1", r1_busy, 1);

        // Owner's controls reach the core combinationally
        @(negedge clk);
        r0_rc = 8'h02;
        r0_rs = 1'b1;
        r0_sp = 1'b1;
        c_din = 8'h91;
        c_err = 1'b1;
        #1;
        chk("mux_rc", c_rc, 8'h02);
        chk("mux_sp", c_sp, 1);
        chk("mux_rs", c_rs, 1);
        chk("rd_dout0", r0_dout, 8'h91);
        chk("rd_dout1", r1_dout, 8'h00);
        chk("rd_err0", r0_err, 1);
        chk("rd_err1", r1_err, 0);
        chk("rd_busy0", r0_busy, 0);

        // Non-owner write strobe and data are dropped
        r1_fw = 1'b1;
        r1_d = 8'h03;
        r0_d = 8'h55;
        #1;
        chk("drop_fw", c_fw, 0);
        chk("drop_d", c_d, 8'h55);
        r0_fw = 1'b1;
        #1;
        chk("own_fw", c_fw, 1);

        // Owner releases while core busy for 5 cycles, req1 pending
        @(negedge clk);
        r0_sp = 1'b0;
        r0_fw = 1'b0;
        c_err = 1'b0;
        c_busy = 1'b1;
        req0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge_chk();
            chk("hold_gnt0", gnt0, 1);
            chk("hold_gnt1", gnt1, 0);
        end
        @(negedge clk);
        c_busy = 1'b0;
        edge_chk();
        chk("hand_gnt1", gnt1, 1);
        chk("hand_gnt0", gnt0, 0);
        chk("hand_busy0", r0_busy, 1);
        chk("hand_fw", c_fw, 1);
        chk("hand_d", c_d, 8'h03);
        chk("hand_dout1", r1_dout, 8'h91);

        // Release to IDLE: core outputs forced low
        @(negedge clk);
        req1 = 1'b0;
        r1_sp = 1'b1;
        edge_chk();
        chk("idle_gnt0", gnt0, 0);
        chk("idle_gnt1", gnt1, 0);
        chk("idle_sp", c_sp, 0);
        chk("idle_fw", c_fw, 0);
        chk("idle_d", c_d, 0);
        r1_sp = 1'b0;
        r1_fw = 1'b0;

        // Round robin with both held; last grant was 1 -> order 0,1,0,1
        @(negedge clk);
        req0 = 1'b1;
        req1 = 1'b1;
        edge_chk();
        chk("rr0_gnt0", gnt0, 1);
        chk("rr0_gnt1", gnt1, 0);
        owner = 0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            req0 = (owner != 0);
            req1 = (owner != 1);
            edge_chk();
            chk("rr_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
            chk("rr_gnt1", gnt1, (i % 2 == 1) ? 1 : 0);
            owner = i % 2;
        end

        // Async reset in GNT1 with core busy
        @(negedge clk);
        r1_sp = 1'b1;
        c_busy = 1'b1;
        #1;
        chk("pre_rst_sp", c_sp, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt1", gnt1, 0);
        chk("arst_sp", c_sp, 0);
        chk("arst_busy1", r1_busy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        r1_sp = 1'b0;
        c_busy = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        edge_chk();
        chk("post_gnt0", gnt0, 1);
        chk("post_gnt1", gnt1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have no parameters; the requester count is fixed at 2 (N = 0, 1).
REQ-002 Clk_i  in  1  single system clock; all state SHALL update on its rising edge.
REQ-003 Reset_n_i  in  1  reset, asynchronous and active-low.
REQ-004 ReqN_i  in  1  requester N asks for ownership of the I2C core; held for the whole multi-transaction sequence.
REQ-005 GntN_o  out  1  requester N owns the core.
REQ-006 ReqN_ReceiveSend_n_i, ReqN_StartProcess_i, ReqN_FIFOReadNext_i, ReqN_FIFOWrite_i  in  1 each  requester N core controls.
REQ-007 ReqN_ReadCount_i, ReqN_Data_i  in  8 each  requester N read count and write data.
REQ-008 ReqN_Busy_o, ReqN_Error_o  out  1 each  core status as seen by requester N.
REQ-009 ReqN_Data_o  out  8  core read data as seen by requester N.
REQ-010 I2C_ReceiveSend_n_o, I2C_StartProcess_o, I2C_FIFOReadNext_o, I2C_FIFOWrite_o  out  1 each  to the core.
REQ-011 I2C_ReadCount_o, I2C_Data_o  out  8 each  to the core.
REQ-012 I2C_Busy_i, I2C_Error_i  in  1 each;  I2C_Data_i  in  8  from the core.

Function
REQ-013 The FSM SHALL have states IDLE, GNT0 and GNT1, plus a 1-bit register LastGnt.
REQ-014 In IDLE with exactly one ReqN_i high, the next state SHALL be GNTN; GntN_o asserts one cycle after ReqN_i is first sampled high.
REQ-015 In IDLE with both requests high, the FSM SHALL grant the requester that is not LastGnt (round robin).
REQ-016 On entry to GNTN, LastGnt SHALL be set to N.
REQ-017 In GNTN, the grant SHALL be held while ReqN_i=1 or I2C_Busy_i=1.
REQ-018 A transaction in flight SHALL never be aborted: if ReqN_i drops while I2C_Busy_i=1, the FSM SHALL stay in GNTN and keep muxing requester N until Busy falls.
REQ-019 Release: in GNTN with ReqN_i=0 and I2C_Busy_i=0, the next state SHALL be GNT(other) if the other request is high (direct handoff, zero idle cycles), otherwise IDLE.
REQ-020 GntN_o SHALL be a registered state decode, so that at most one grant is high in any cycle.
REQ-021 In GNTN, the core-facing outputs SHALL combinationally equal requester N's corresponding inputs.
REQ-022 In IDLE, all core-facing outputs SHALL be 0.
REQ-023 Granted requester N: ReqN_Busy_o = I2C_Busy_i, ReqN_Error_o = I2C_Error_i, ReqN_Data_o = I2C_Data_i.
REQ-024 Non-granted requester: ReqN_Busy_o = 1, ReqN_Error_o = 0, ReqN_Data_o = 0.
REQ-025 Controls asserted by a non-granted requester (StartProcess, FIFOWrite, FIFOReadNext) SHALL be dropped, not queued.
REQ-026 A request and a release by the other requester in the same cycle SHALL produce a handoff on the next edge, with no glitch on either grant.

Reset
REQ-027 While Reset_n_i=0, the block SHALL be asynchronously forced to state IDLE and LastGnt=1, so requester 0 wins the first contention.
REQ-028 During reset, Gnt0_o=Gnt1_o=0, all core-facing outputs are 0, both ReqN_Busy_o=1, and both ReqN_Error_o and ReqN_Data_o are 0.
REQ-029 Reset asserted mid-transaction SHALL drop the grant immediately; no state survives reset.

Verification
REQ-030 After reset, pulse Req0_i=Req1_i=1 in the same cycle -> Gnt0_o=1 one cycle later, Gnt1_o=0, Req1_Busy_o=1.
REQ-031 Req0 granted; drive Req0_ReadCount_i=0x02, Req0_ReceiveSend_n_i=1, Req0_StartProcess_i=1 -> I2C_ReadCount_o=0x02 and I2C_StartProcess_o=1 in the same cycle; I2C_Data_i=0x91 -> Req0_Data_o=0x91, Req1_Data_o=0x00.
REQ-032 Req0 drops while I2C_Busy_i=1 for 5 cycles with Req1 pending -> Gnt0_o held 5 cycles; Gnt1_o=1 on the edge after Busy falls; no IDLE cycle between grants.
REQ-033 Both requests held continuously, each releasing after one transaction -> grant order 0, 1, 0, 1.
REQ-034 Req1 asserts Req1_FIFOWrite_i=1 with Req1_Data_i=0x03 while Gnt0_o=1 -> I2C_FIFOWrite_o follows requester 0 only; 0x03 never appears on I2C_Data_o.
REQ-035 Reset_n_i pulsed low during GNT1 with Busy=1 -> Gnt1_o=0 asynchronously and I2C_StartProcess_o=0; the next contention grants requester 0.
